// File: rtl/serial_port_rx.sv
`default_nettype none
// =============================================================================
//  Module      : serial_port_rx
//  Description : 8N1 (or 8E1 with SERIAL_RX_PARITY_EN) serial receiver sampling
//                mid-bit on a shared 4-phase baud tick, with an FWFT byte FIFO.
//  Revision    : 1.0 - initial release
// =============================================================================
module serial_port_rx #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    phase,
    input  logic          change,
    input  logic          rx,
    input  logic          rx_rd,
    output logic [7:0]    rx_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    output logic          frame_err,
    output logic          parity_err
);

    localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY = 3'd2,
`endif
        S_STOP   = 3'd3,
        S_BRK    = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     sr_q, sr_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           sync1_q, rx_s_q;
    logic           frame_err_q, frame_err_d;
    logic           overrun_q;
    logic           w_sample;
    logic           w_push;
    logic           w_pop;
    logic           w_wr;
    logic           w_full;
    logic           w_ovr;

    logic [7:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;

`ifdef SERIAL_RX_PARITY_EN
    logic           perr_q, perr_d;
    logic           parity_err_q, parity_err_d;
`endif

    // Idle-high line: both synchroniser stages reset to 1 so no false start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    assign w_sample = change && (phase == 2'h2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sr_q        <= 8'h00;
            cnt_q       <= 3'd0;
            frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
`ifdef SERIAL_RX_PARITY_EN
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        w_push      = 1'b0;
        frame_err_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        perr_d       = perr_q;
        parity_err_d = 1'b0;
`endif
        if (w_sample) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        cnt_d   = 3'd0;
                    end
                end
                S_DATA: begin
                    sr_d  = {rx_s_q, sr_q[7:1]};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                S_PARITY: begin
                    perr_d  = (rx_s_q != ^sr_q);
                    state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    if (rx_s_q) begin
`ifdef SERIAL_RX_PARITY_EN
                        if (perr_q) parity_err_d = 1'b1;
                        else        w_push       = 1'b1;
`else
                        w_push = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BRK;
                    end
                end
                // A held-low line reports once, then waits for the line to recover.
                S_BRK: begin
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign w_full = (count_q == c_FULL_CNT);
    assign w_pop  = rx_rd && (count_q != '0);
    // When full, a simultaneous pop frees the slot the write pointer is aimed at.
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_ovr  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q] <= sr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= w_ovr;
            if (w_wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({w_wr, w_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rx_data   = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = w_full;
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
